// File: rtl/fir_tap_buffer.sv
// fir_tap_buffer: circular sample store for the FIR datapath.
//
// Samples are written into a ring at write pointer wp. Logical tap index k
// (0 = newest) maps to physical slot (wp-1-k) mod DEPTH. A tap that has not
// been written since the last flush reads as zero. The memory itself is
// never cleared; only the fill count masks stale history.
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset (flush + zero tap outputs)
//   clr          synchronous flush: empties buffer, aborts sweep
//   in_valid     sample present
//   in_ready     buffer accepts sample (low while a sweep runs)
//   in_data      sample
//   rd_en        single tap read request (1-cycle latency)
//   rd_addr      logical tap index to read
//   sweep_start  stream all DEPTH taps, newest first, on consecutive cycles
//   tap_valid    tap_data/tap_idx valid this cycle
//   tap_data     tap value
//   tap_idx      logical index of tap_data
//   tap_last     final tap of a sweep
//   busy         sweep in progress
//   fill_count   samples held, saturates at DEPTH
//   full         fill_count == DEPTH
module fir_tap_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              sweep_start,
  output logic              tap_valid,
  output logic [DATA_W-1:0] tap_data,
  output logic [ADDR_W-1:0] tap_idx,
  output logic              tap_last,
  output logic              busy,
  output logic [ADDR_W:0]   fill_count,
  output logic              full
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W:0]   fill_q, fill_d;
  logic              tap_valid_q, tap_valid_d;
  logic              tap_last_q, tap_last_d;
  logic [DATA_W-1:0] tap_data_q, tap_data_d;
  logic [ADDR_W-1:0] tap_idx_q, tap_idx_d;

  logic              push;
  logic [ADDR_W-1:0] rd_phys, sw_phys;
  logic [DATA_W-1:0] rd_val, sw_val;

  // (wp-1-k) mod DEPTH without a divider: wp + DEPTH-1 - k lies in
  // [0, 2*DEPTH-2] for k < DEPTH, so one conditional subtract suffices.
  function automatic logic [ADDR_W-1:0] phys_idx(input logic [ADDR_W-1:0] wp,
                                                 input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] sum;
    sum = {1'b0, wp} + {1'b0, LastIdx} - {1'b0, k};
    if (sum >= DepthW) begin
      sum = sum - DepthW;
    end
    return sum[ADDR_W-1:0];
  endfunction

  // A tap is real only if it was written since the last flush.
  function automatic logic tap_ok(input logic [ADDR_W-1:0] k, input logic [ADDR_W:0] fill);
    return ({1'b0, k} < fill) && ({1'b0, k} < DepthW);
  endfunction

  assign busy       = (state_q == StSweep);
  assign in_ready   = !busy;
  assign fill_count = fill_q;
  assign full       = (fill_q == DepthW);
  assign tap_valid  = tap_valid_q;
  assign tap_last   = tap_last_q;
  assign tap_data   = tap_data_q;
  assign tap_idx    = tap_idx_q;

  assign push = in_valid && in_ready && !clr && !rst;

  always_comb begin
    rd_phys = phys_idx(wp_q, rd_addr);
    sw_phys = phys_idx(wp_q, cnt_q);
    rd_val  = tap_ok(rd_addr, fill_q) ? mem[rd_phys] : '0;
    sw_val  = tap_ok(cnt_q, fill_q) ? mem[sw_phys] : '0;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wp_d        = wp_q;
    fill_d      = fill_q;
    tap_valid_d = 1'b0;
    tap_last_d  = 1'b0;
    tap_data_d  = tap_data_q;
    tap_idx_d   = tap_idx_q;

    if (clr) begin
      state_d = StIdle;
      cnt_d   = '0;
      wp_d    = '0;
      fill_d  = '0;
    end else begin
      if (push) begin
        wp_d   = (wp_q == LastIdx) ? '0 : wp_q + 1'b1;
        fill_d = (fill_q == DepthW) ? fill_q : fill_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (sweep_start) begin
            state_d = StSweep;
            cnt_d   = '0;
          end else if (rd_en) begin
            // Reads the pre-edge contents; a same-cycle push is not visible.
            tap_valid_d = 1'b1;
            tap_idx_d   = rd_addr;
            tap_data_d  = rd_val;
          end
        end
        StSweep: begin
          tap_valid_d = 1'b1;
          tap_idx_d   = cnt_q;
          tap_data_d  = sw_val;
          tap_last_d  = (cnt_q == LastIdx);
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == LastIdx) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      wp_q        <= '0;
      fill_q      <= '0;
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      tap_data_q  <= '0;
      tap_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      tap_valid_q <= tap_valid_d;
      tap_last_q  <= tap_last_d;
      tap_data_q  <= tap_data_d;
      tap_idx_q   <= tap_idx_d;
    end
  end

  // Sample storage has no reset: stale contents are hidden by fill_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_fir_tap_buffer.sv
module tb_fir_tap_buffer;

  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        rd_en = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic        sweep_start = 1'b0;
  logic        tap_valid;
  logic [15:0] tap_data;
  logic [2:0]  tap_idx;
  logic        tap_last;
  logic        busy;
  logic [3:0]  fill_count;
  logic        full;

  fir_tap_buffer #(
    .DATA_W(16),
    .DEPTH (DEP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .sweep_start(sweep_start),
    .tap_valid  (tap_valid),
    .tap_data   (tap_data),
    .tap_idx    (tap_idx),
    .tap_last   (tap_last),
    .busy       (busy),
    .fill_count (fill_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  i;
    logic        l;
  } exp_t;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rd;
    logic [2:0]  a;
    logic        etv;
    logic [15:0] etd;
    int          efill;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          m_left = 0;   // sweep taps still to come
  logic [15:0] hist[$];      // newest first, at most DEP entries
  exp_t        exp_q[$];
  vec_t        vt[8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] model_tap(input int k);
    if (k < hist.size()) return hist[k];
    return 16'h0;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (tap_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL tap_unexpected: got idx %0d data %0h, want no tap", tap_idx, tap_data);
      end else begin
        e = exp_q.pop_front();
        chk("tap_out", 32'({tap_data, tap_idx, tap_last}), 32'(e));
      end
    end
  endtask

  task automatic cyc(input logic v, input logic [15:0] d, input logic rd, input logic [2:0] a,
                     input logic sw, input logic c);
    logic exp_tv;
    exp_tv      = 1'b0;
    in_valid    = v;
    in_data     = d;
    rd_en       = rd;
    rd_addr     = a;
    sweep_start = sw;
    clr         = c;
    chk("in_ready", 32'(in_ready), 32'(m_left == 0));
    if (c) begin
      exp_q.delete();
      hist.delete();
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      exp_tv = 1'b1;
    end else begin
      if (rd && !sw) begin
        exp_q.push_back('{d: model_tap(int'(a)), i: a, l: 1'b0});
        exp_tv = 1'b1;
      end
      if (v) begin
        hist.push_front(d);
        if (hist.size() > DEP) void'(hist.pop_back());
      end
      if (sw) begin
        for (int k = 0; k < DEP; k++) begin
          exp_q.push_back('{d: model_tap(k), i: 3'(k), l: (k == DEP - 1)});
        end
        m_left = DEP;
      end
    end
    step();
    chk("tap_valid", 32'(tap_valid), 32'(exp_tv));
    if (!exp_tv) chk("tap_last_idle", 32'(tap_last), 32'(0));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("fill_count", 32'(fill_count), 32'(hist.size()));
    chk("full", 32'(full), 32'(hist.size() == DEP));
    in_valid    = 1'b0;
    rd_en       = 1'b0;
    sweep_start = 1'b0;
    clr         = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    rst         = 1'b1;
    clr         = 1'b0;
    in_valid    = 1'b0;
    rd_en       = 1'b0;
    sweep_start = 1'b0;
    exp_q.delete();
    hist.delete();
    m_left = 0;
    step();
    rst = 1'b0;
    chk("rst_tap_valid", 32'(tap_valid), 32'(0));
    chk("rst_tap_data", 32'(tap_data), 32'(0));
    chk("rst_tap_idx", 32'(tap_idx), 32'(0));
    chk("rst_tap_last", 32'(tap_last), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_fill", 32'(fill_count), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //        v     d         rd    a     etv   etd       fill
    vt[0] = '{1'b1, 16'h0011, 1'b0, 3'd0, 1'b0, 16'h0000, 1};
    vt[1] = '{1'b1, 16'h0022, 1'b0, 3'd0, 1'b0, 16'h0000, 2};
    vt[2] = '{1'b1, 16'h0033, 1'b0, 3'd0, 1'b0, 16'h0000, 3};
    vt[3] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 16'h0033, 3};
    vt[4] = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 16'h0022, 3};
    vt[5] = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 16'h0011, 3};
    vt[6] = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 16'h0000, 3};
    vt[7] = '{1'b0, 16'h0000, 1'b1, 3'd7, 1'b1, 16'h0000, 3};

    do_rst();
    for (int i = 0; i < 8; i++) begin
      cyc(vt[i].v, vt[i].d, vt[i].rd, vt[i].a, 1'b0, 1'b0);
      chk("vec_tap_valid", 32'(tap_valid), 32'(vt[i].etv));
      if (vt[i].etv) chk("vec_tap_data", 32'(tap_data), 32'(vt[i].etd));
      chk("vec_fill", 32'(fill_count), 32'(vt[i].efill));
    end

    // Overfill then sweep newest first.
    do_rst();
    for (int i = 1; i <= 10; i++) cyc(1'b1, 16'(i), 1'b0, 3'd0, 1'b0, 1'b0);
    chk("full_after_10", 32'(full), 32'(1));
    chk("fill_after_10", 32'(fill_count), 32'(8));
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    chk("busy_at_start", 32'(busy), 32'(1));
    for (int k = 0; k < DEP; k++) begin
      idle(1);
      chk("sweep_data", 32'(tap_data), 32'(10 - k));
      chk("sweep_idx", 32'(tap_idx), 32'(k));
      chk("sweep_last", 32'(tap_last), 32'(k == DEP - 1));
    end
    chk("busy_after_sweep", 32'(busy), 32'(0));

    // Pushes refused during a sweep, accepted once it ends.
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < DEP; k++) begin
      cyc(1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0, 1'b0);
      chk("sweep_unchanged", 32'(tap_data), 32'(10 - k));
    end
    cyc(1'b1, 16'hBEEF, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("read_beef", 32'(tap_data), 32'h0000BEEF);
    cyc(1'b0, 16'h0, 1'b1, 3'd1, 1'b0, 1'b0);
    chk("read_after_beef", 32'(tap_data), 32'd10);

    // Same-cycle push with read and with sweep_start.
    do_rst();
    cyc(1'b1, 16'h0044, 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b1, 16'h0055, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("push_read_same", 32'(tap_data), 32'h0044);
    cyc(1'b1, 16'h0066, 1'b0, 3'd0, 1'b1, 1'b0);
    idle(1);
    chk("push_sweep_first", 32'(tap_data), 32'h0066);
    chk("push_sweep_idx0", 32'(tap_idx), 32'(0));
    idle(DEP - 1);

    // clr at the third tap aborts the sweep and empties the buffer.
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    idle(2);
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    chk("clr_no_last", 32'(tap_last), 32'(0));
    chk("clr_fill", 32'(fill_count), 32'(0));
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < DEP; k++) begin
      idle(1);
      chk("sweep_after_clr", 32'(tap_data), 32'(0));
    end

    // rst mid-sweep with a full buffer.
    for (int i = 0; i < DEP; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 3'd0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 3'd0, 1'b1, 1'b0);
    idle(3);
    do_rst();
    cyc(1'b0, 16'h0, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("read_after_rst", 32'(tap_data), 32'(0));

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
